led_trail_pwm: RTL and testbench
================================

// Module: led_trail_pwm
// PURPOSE
//   Downstream consumer of the bouncing one-hot LED pattern generator. Turns the
//   8-bit position pattern into 8 PWM-dimmed LED drives with a fading "comet
//   tail": a lit position jumps to full brightness, then decays in fixed steps
//   after the pattern moves on. Drives the board LED pins directly.
// PARAMETERS
//   WIDTH       8    number of LED channels (pattern_in / led_out width)
//   PWM_BITS    4    brightness resolution; PWM_MAX = 2**PWM_BITS-1 (15)
//   DECAY_DIV   64   clk cycles per decay tick; legal range >= 2
//   DECAY_STEP  2    brightness subtracted per decay tick; 1..PWM_MAX
// PORTS
//   clk         in   1      system clock, all logic on posedge
//   reset       in   1      synchronous, active-low
//   enable      in   1      1 = trail/PWM mode, 0 = bypass (raw pattern)
//   pattern_in  in   WIDTH  position pattern from generator, normally one-hot
//   led_out     out  WIDTH  registered LED drive, 1 = LED on
//   all_dark    out  1      registered, 1 when every channel level == 0
// BEHAVIOUR
//   Reset (reset==0 at posedge): level[i]=0, pwm_cnt=0, pre_cnt=0, led_out=0,
//     all_dark=1. Takes priority over all other inputs; valid mid-fade.
//   pwm_cnt: PWM_BITS wide, counts 0..PWM_MAX-1 then wraps to 0 (period 15).
//     Free-runs in both modes.
//   pre_cnt: counts 0..DECAY_DIV-1, wraps; decay_tick=1 for the single cycle
//     pre_cnt==DECAY_DIV-1. Held at 0 while enable==0.
//   Per channel level[i] (PWM_BITS wide), enable==1, priority order:
//     1. pattern_in[i]==1            -> level[i] <= PWM_MAX
//     2. decay_tick                  -> level[i] <= (level>DECAY_STEP) ?
//                                        level-DECAY_STEP : 0  (saturate at 0)
//     3. otherwise                   -> hold
//     Load beats decay when both occur in the same cycle.
//   Per channel, enable==0: level[i] <= pattern_in[i] ? PWM_MAX : 0 (no tail).
//   led_out[i] <= enable ? (level[i] > pwm_cnt) : pattern_in[i].
//     level 15 -> always on, level 0 -> always off, level L -> L/15 duty.
//   Latency (enable==1): pattern_in[i] rising at edge N -> level=15 at N+1 ->
//     led_out[i]=1 from edge N+2. Bypass latency: 1 cycle.
//   all_dark <= (all next-state levels == 0); from 15 with defaults, dark
//     after 8 decay ticks (15,13,11,9,7,5,3,1,0), <= 8*64+2 cycles.
//   Multi-hot or all-zero pattern_in is legal; each bit handled independently.
//   enable 1->0: tails cleared next edge; 0->1: fade starts from loaded levels,
//     pre_cnt restarts at 0 (first tick DECAY_DIV cycles later).
// STRUCTURE
//   Package led_pkg: PWM_MAX, level_t (logic [PWM_BITS-1:0]), default
//     DECAY_DIV/DECAY_STEP constants shared with the pattern generator.
//   Top holds pwm_cnt, pre_cnt, all_dark reduction.
//   Sub-module led_pwm_channel: one level register, load/decay logic and
//     registered comparator; instantiated WIDTH times in a generate loop.
// TESTING
//   1 reset=0 for 3 cycles, pattern 8'hFF -> led_out=8'h00, all_dark=1.
//   2 enable=1, pattern 8'h01 one cycle then 8'h00 -> led_out[0] 15/15 duty
//     until first tick, then 13/15,11/15..1/15, 0; all_dark=1 within 514 cyc.
//   3 pattern held 8'h80 -> led_out==8'h80 every cycle from 2nd edge on,
//     all_dark stays 0.
//   4 pattern_in[3]=1 exactly on decay_tick cycle -> level[3]=15 (not 13).
//   5 enable=0, pattern 8'h24 -> led_out=8'h24 one cycle later, no tail after
//     pattern 8'h00; enable 0->1 mid-pattern -> fade from 15, tick after 64.
//   6 reset=0 mid-fade (level[2]=7) -> next edge led_out=0, all_dark=1.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the LED pattern generator and the trail/PWM stage.
// The trail stage takes its default dimming and decay settings from here.
package led_pkg;

   localparam int PWM_BITS       = 4;
   localparam int PWM_MAX        = (1 << PWM_BITS) - 1;
   localparam int DECAY_DIV_DEF  = 64;
   localparam int DECAY_STEP_DEF = 2;

   typedef logic [PWM_BITS-1:0] level_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: a brightness level that loads to full on a pattern hit and
// decays on ticks, plus a registered PWM comparator driving the pin.
module led_pwm_channel
   import led_pkg::*;
#(
   parameter int PWM_BITS   = led_pkg::PWM_BITS,
   parameter int DECAY_STEP = DECAY_STEP_DEF
) (
   input  logic                clk,
   input  logic                reset_ni,
   input  logic                enable_i,
   input  logic                pattern_i,
   input  logic                tick_i,
   input  logic [PWM_BITS-1:0] pwm_cnt_i,
   output logic                led_o,
   output logic                dark_next_o
);

   localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
   localparam logic [PWM_BITS-1:0] LVL_STEP = PWM_BITS'(DECAY_STEP);

   logic [PWM_BITS-1:0] level_q, level_d;
   logic                led_q;

   // A pattern hit wins over a decay tick landing in the same cycle.
   always_comb begin
      level_d = level_q;
      if (!enable_i) begin
         level_d = pattern_i ? LVL_MAX : '0;
      end else if (pattern_i) begin
         level_d = LVL_MAX;
      end else if (tick_i) begin
         level_d = (level_q > LVL_STEP) ? (level_q - LVL_STEP) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_ni) begin
         level_q <= '0;
         led_q   <= 1'b0;
      end else begin
         level_q <= level_d;
         led_q   <= enable_i ? (level_q > pwm_cnt_i) : pattern_i;
      end
   end

   assign led_o       = led_q;
   assign dark_next_o = (level_d == '0);

endmodule

// File: rtl/led_trail_pwm.sv
// Turns the bouncing one-hot position pattern into PWM-dimmed LED drives with a
// fading comet tail; bypass mode passes the raw pattern through one register.
module led_trail_pwm
   import led_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PWM_BITS   = led_pkg::PWM_BITS,
   parameter int DECAY_DIV  = DECAY_DIV_DEF,
   parameter int DECAY_STEP = DECAY_STEP_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] pattern_in,
   output logic [WIDTH-1:0] led_out,
   output logic             all_dark
);

   localparam int PRE_W = $clog2(DECAY_DIV);
   localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
   localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DECAY_DIV - 1);

   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
   logic                decay_tick;
   logic                all_dark_q;
   logic [WIDTH-1:0]    dark_next;

   // PWM period is PWM_MAX so that full level means always on.
   assign pwm_cnt_d  = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
   assign decay_tick = enable && (pre_cnt_q == PRE_LAST);

   always_comb begin
      pre_cnt_d = '0;
      if (enable) begin
         pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pwm_cnt_q  <= '0;
         pre_cnt_q  <= '0;
         all_dark_q <= 1'b1;
      end else begin
         pwm_cnt_q  <= pwm_cnt_d;
         pre_cnt_q  <= pre_cnt_d;
         all_dark_q <= &dark_next;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      led_pwm_channel #(
         .PWM_BITS   (PWM_BITS),
         .DECAY_STEP (DECAY_STEP)
      ) u_ch (
         .clk         (clk),
         .reset_ni    (reset),
         .enable_i    (enable),
         .pattern_i   (pattern_in[i]),
         .tick_i      (decay_tick),
         .pwm_cnt_i   (pwm_cnt_q),
         .led_o       (led_out[i]),
         .dark_next_o (dark_next[i])
      );
   end

   assign all_dark = all_dark_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm: a cycle model predicts {all_dark, led_out}
// into a scoreboard queue as each input cycle is driven.
module tb_led_trail_pwm;
   import led_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] pattern_in;
   logic [7:0] led_out;
   logic       all_dark;

   always #5 clk = ~clk;

   led_trail_pwm dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .pattern_in (pattern_in),
      .led_out    (led_out),
      .all_dark   (all_dark)
   );

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [8:0] sb_q[$];

   int         m_lvl[8];
   int         m_pwm;
   int         m_pre;
   logic [7:0] m_led;
   logic       m_dark;

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic en, input logic [7:0] pat);
      bit tick;
      int nl;
      if (!r) begin
         for (int i = 0; i < 8; i++) m_lvl[i] = 0;
         m_pwm  = 0;
         m_pre  = 0;
         m_led  = '0;
         m_dark = 1'b1;
      end else begin
         tick   = en && (m_pre == DECAY_DIV_DEF - 1);
         m_dark = 1'b1;
         for (int i = 0; i < 8; i++) begin
            m_led[i] = en ? (m_lvl[i] > m_pwm) : pat[i];
            if (pat[i])    nl = PWM_MAX;
            else if (!en)  nl = 0;
            else if (tick) begin
               nl = m_lvl[i] - DECAY_STEP_DEF;
               if (nl < 0) nl = 0;
            end else       nl = m_lvl[i];
            m_lvl[i] = nl;
            if (nl != 0) m_dark = 1'b0;
         end
         m_pwm = (m_pwm + 1) % PWM_MAX;
         m_pre = en ? (m_pre + 1) % DECAY_DIV_DEF : 0;
      end
   endtask

   task automatic cycle(input logic r, input logic en, input logic [7:0] pat, input string tag);
      logic [8:0] e;
      reset      = r;
      enable     = en;
      pattern_in = pat;
      model_step(r, en, pat);
      sb_q.push_back({m_dark, m_led});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check(tag, {all_dark, led_out}, e);
   endtask

   initial begin
      int    first_dark;
      int    on_cnt;
      level_t lvl_probe;

      reset      = 1'b0;
      enable     = 1'b0;
      pattern_in = '0;

      // Reset dominates a full pattern.
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 8'hFF, "reset");
         check("reset_const", {all_dark, led_out}, 9'h100);
      end

      // Single hit on channel 0, then a full fade to dark.
      cycle(1'b1, 1'b1, 8'h01, "load0");
      first_dark = -1;
      for (int i = 0; i < 600; i++) begin
         cycle(1'b1, 1'b1, 8'h00, "fade0");
         if (all_dark && first_dark < 0) first_dark = i + 2;
      end
      check("dark_within_514", 9'((first_dark > 0) && (first_dark <= 514)), 9'h001);

      // Held position stays fully lit.
      cycle(1'b1, 1'b1, 8'h80, "hold_first");
      for (int i = 0; i < 70; i++) begin
         cycle(1'b1, 1'b1, 8'h80, "hold");
         check("hold_const", {all_dark, led_out}, 9'h080);
      end

      // Load on channel 3 landing exactly on a decay tick.
      cycle(1'b1, 1'b1, 8'h08, "load3");
      for (int i = 0; i < 64 && m_pre != DECAY_DIV_DEF - 1; i++) cycle(1'b1, 1'b1, 8'h00, "wait_tick");
      cycle(1'b1, 1'b1, 8'h00, "tick_a");
      for (int i = 0; i < 64 && m_pre != DECAY_DIV_DEF - 1; i++) cycle(1'b1, 1'b1, 8'h00, "wait_tick");
      cycle(1'b1, 1'b1, 8'h08, "tick_load");
      cycle(1'b1, 1'b1, 8'h00, "tick_post");
      on_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         cycle(1'b1, 1'b1, 8'h00, "tick_duty");
         on_cnt += int'(led_out[3]);
      end
      check("load_beats_decay", 9'(on_cnt), 9'd15);

      // Bypass: raw pattern, one cycle latency, no tail.
      cycle(1'b1, 1'b0, 8'h24, "bypass");
      check("bypass_const", {all_dark, led_out}, 9'h024);
      cycle(1'b1, 1'b0, 8'h00, "bypass_off");
      check("bypass_off_const", {all_dark, led_out}, 9'h100);
      cycle(1'b1, 1'b0, 8'h00, "no_tail");
      check("no_tail_const", {all_dark, led_out}, 9'h100);

      // Enable rising mid-pattern: fade from full, first tick 64 cycles later.
      cycle(1'b1, 1'b0, 8'h24, "pre_enable");
      cycle(1'b1, 1'b1, 8'h24, "en_rise");
      on_cnt = 0;
      for (int i = 0; i < 63; i++) begin
         cycle(1'b1, 1'b1, 8'h00, "refade_full");
         on_cnt += int'(led_out[2]);
      end
      check("full_until_tick", 9'(on_cnt), 9'd63);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'h00, "refade");

      // Reset mid-fade at level 7 on channel 2.
      for (int i = 0; i < 400 && m_lvl[2] != 7; i++) cycle(1'b1, 1'b1, 8'h00, "to_level7");
      lvl_probe = level_t'(m_lvl[2]);
      cycle(1'b0, 1'b1, 8'h00, "reset_mid");
      check("reset_mid_const", {all_dark, led_out}, 9'h100);
      cycle(1'b1, 1'b1, 8'h00, "after_reset");
      check("after_reset_const", {all_dark, led_out}, 9'h100);
      if (lvl_probe != level_t'(7)) begin
         n_fail++;
         $display("FAIL level7_reached observed=%0d expected=7", lvl_probe);
      end

      check("scoreboard_empty", 9'(sb_q.size()), 9'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
